// File: rtl/timing_gen_pkg.sv
// Shared types and defaults for the CMLK timing generator.
// Optional external trigger support is selected with TIMING_CNT_EXT_TRIG_EN.
package timing_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int DEF_CNT_WIDTH   = 32;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_FRAME_WIDTH = 16;

endpackage

// Channel ch of a flattened compare bus (ch0 in the LSBs), each w bits wide.
`define TCG_CH_SLICE(bus, ch, w) bus[(ch)*(w) +: (w)]

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for the external trigger.
// Used only when TIMING_CNT_EXT_TRIG_EN is defined; trigger-to-pulse is 3 clocks.
module trig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_async,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= trig_async;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/timing_cnt_gen.sv
// Master frame counter with frame-boundary shadow loading of period and compare words.
// TIMING_CNT_EXT_TRIG_EN adds ext_trig and an ARMED state between start and the first frame.
//
// state    | meaning
// ST_IDLE  | stopped, compares forced 0, waiting for start
// ST_ARMED | started, outputs idle-forced, waiting for ext_trig edge (optional)
// ST_RUN   | counting frames
module timing_cnt_gen
  import timing_gen_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int FRAME_WIDTH = DEF_FRAME_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        update_req,
  input  logic [CNT_WIDTH-1:0]        period_in,
  input  logic [FRAME_WIDTH-1:0]      frame_num_in,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cmp_rise_in,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cmp_fall_in,
`ifdef TIMING_CNT_EXT_TRIG_EN
  input  logic                        ext_trig,
`endif
  output logic [CNT_WIDTH-1:0]        cnt_out,
  output logic [NUM_CH*CNT_WIDTH-1:0] cmp_rise_out,
  output logic [NUM_CH*CNT_WIDTH-1:0] cmp_fall_out,
  output logic                        frame_start,
  output logic [FRAME_WIDTH-1:0]      frame_cnt_out,
  output logic                        busy,
  output logic                        done,
  output logic                        update_ack
);

  localparam int BUS_W = NUM_CH * CNT_WIDTH;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   period_q;
  logic [FRAME_WIDTH-1:0] frame_num_q;
  logic [BUS_W-1:0]       rise_sh;
  logic [BUS_W-1:0]       fall_sh;
  logic                   stop_pending;
  logic                   upd_pending;

  logic                   at_wrap;
  logic [FRAME_WIDTH-1:0] fc_next;
  logic [CNT_WIDTH-1:0]   period_clamped;
  logic                   run_ends;

  assign at_wrap        = (cnt_out == period_q - CNT_WIDTH'(1));
  assign fc_next        = frame_cnt_out + FRAME_WIDTH'(1);
  assign period_clamped = (period_in == '0) ? CNT_WIDTH'(1) : period_in;
  assign run_ends       = ((frame_num_q != '0) && (fc_next == frame_num_q)) || stop_pending;

`ifdef TIMING_CNT_EXT_TRIG_EN
  logic trig_pulse;

  trig_sync_edge u_trig_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_async (ext_trig),
    .pulse      (trig_pulse)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      period_q      <= '0;
      frame_num_q   <= '0;
      rise_sh       <= '0;
      fall_sh       <= '0;
      stop_pending  <= 1'b0;
      upd_pending   <= 1'b0;
      cnt_out       <= '0;
      cmp_rise_out  <= '0;
      cmp_fall_out  <= '0;
      frame_start   <= 1'b0;
      frame_cnt_out <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      update_ack    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      update_ack  <= 1'b0;
      if (update_req) upd_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            period_q      <= period_clamped;
            frame_num_q   <= frame_num_in;
            rise_sh       <= cmp_rise_in;
            fall_sh       <= cmp_fall_in;
            upd_pending   <= update_req;
            update_ack    <= 1'b1;
            stop_pending  <= 1'b0;
            busy          <= 1'b1;
            cnt_out       <= '0;
            frame_cnt_out <= '0;
`ifdef TIMING_CNT_EXT_TRIG_EN
            state         <= ST_ARMED;
`else
            state         <= ST_RUN;
            frame_start   <= 1'b1;
            cmp_rise_out  <= cmp_rise_in;
            cmp_fall_out  <= cmp_fall_in;
`endif
          end
        end

`ifdef TIMING_CNT_EXT_TRIG_EN
        ST_ARMED: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (trig_pulse) begin
            state        <= ST_RUN;
            frame_start  <= 1'b1;
            cnt_out      <= '0;
            cmp_rise_out <= rise_sh;
            cmp_fall_out <= fall_sh;
          end
        end
`endif

        ST_RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (at_wrap) begin
            frame_cnt_out <= fc_next;
            cnt_out       <= '0;
            if (run_ends) begin
              state        <= ST_IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              stop_pending <= 1'b0;
              cmp_rise_out <= '0;
              cmp_fall_out <= '0;
            end else begin
              frame_start <= 1'b1;
              // A request seen only at this edge waits for the next wrap.
              if (upd_pending) begin
                period_q     <= period_clamped;
                rise_sh      <= cmp_rise_in;
                fall_sh      <= cmp_fall_in;
                cmp_rise_out <= cmp_rise_in;
                cmp_fall_out <= cmp_fall_in;
                update_ack   <= 1'b1;
                upd_pending  <= update_req;
              end
            end
          end else begin
            cnt_out <= cnt_out + CNT_WIDTH'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/timing_cnt_gen.md
Name: timing_cnt_gen

Overview:
- Master frame counter for the CMLK timing generator.
- Produces the free-running cnt and the per-channel rise/fall compare words that feed the per-bit comparator stages directly downstream.
- Runs for N frames or continuously. Shadow-loads period and compare values at frame boundaries so the downstream edges never glitch mid-frame.
- Provides start/stop control, status and frame-boundary strobes to the AXI register block.

Parameters:
CNT_WIDTH, 32, width of counter, period and compare words
NUM_CH, 4, number of output channels (compare pairs)
FRAME_WIDTH, 16, width of frame-count and frame-number fields

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle run request
stop  in  1  one-cycle graceful-stop request
update_req  in  1  one-cycle request to apply new shadow values at the next frame boundary
period_in  in  CNT_WIDTH  frame length in clocks
frame_num_in  in  FRAME_WIDTH  frames to run; 0 = continuous
cmp_rise_in  in  NUM_CH*CNT_WIDTH  per-channel rise thresholds, ch0 in the LSBs
cmp_fall_in  in  NUM_CH*CNT_WIDTH  per-channel fall thresholds
cnt_out  out  CNT_WIDTH  frame counter to the comparator stages
cmp_rise_out  out  NUM_CH*CNT_WIDTH  active rise thresholds
cmp_fall_out  out  NUM_CH*CNT_WIDTH  active fall thresholds
frame_start  out  1  pulse in the cycle cnt_out==0 of each frame
frame_cnt_out  out  FRAME_WIDTH  completed frames since start
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse on return to IDLE
update_ack  out  1  one-cycle pulse when shadow values were applied

Behaviour:
- Reset: all outputs 0, state IDLE, all shadow registers 0, pending flags cleared. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, RUN (plus ARMED when the optional feature is enabled).
- IDLE -> RUN: start sampled high at cycle T. At T+1:
  - busy=1, cnt_out=0, frame_start=1, frame_cnt_out=0.
  - period, frame_num and compares are loaded from the inputs.
- Period clamp: period_q = max(period_in, 1).
- Counting in RUN: cnt_out increments by 1 each clock. When cnt_out==period_q-1, the next cycle has cnt_out=0, frame_start=1 and frame_cnt_out+1 (a completed frame).
- frame_cnt_out wraps modulo 2^FRAME_WIDTH in continuous mode.
- End condition, evaluated at each wrap. Either condition returns to IDLE instead of starting a new frame:
  - frame_num_q!=0 and the incremented count==frame_num_q, or
  - stop_pending is set.
- Return to IDLE (same cycle):
  - done=1 for one cycle, busy=0, cnt_out=0.
  - cmp_rise_out and cmp_fall_out forced to 0, so the downstream bit is guaranteed 0.
  - frame_cnt_out holds its final value.
- stop in RUN sets stop_pending; the current frame always completes. stop in IDLE has no effect. start in RUN is ignored.
- Simultaneous start and stop in IDLE: start wins and stop is discarded.
- update_req sets upd_pending in any state.
- Shadow update at a wrap that continues running:
  - period_q and all compare shadows reload from the inputs; frame_num_q does not change.
  - update_ack=1 in the same cycle as the new frame_start; upd_pending clears.
- update_req arriving in the wrap cycle itself is serviced at the following wrap.
- A start load also clears upd_pending and pulses update_ack.
- Compare outputs are registered and change only on start or wrap cycles. cnt_out and compares are aligned in the same cycle, so downstream latency is unaffected.

Optional Feature:
- Macro: TIMING_CNT_EXT_TRIG_EN.
- When defined:
  - Adds input ext_trig (1 bit, asynchronous). It passes through a 2-FF synchronizer plus rising-edge detect (3 cycles trigger-to-detect).
  - start moves IDLE -> ARMED with busy=1 and outputs idle-forced.
  - ARMED -> RUN on the detected edge; the first frame_start comes 1 cycle after detect.
  - stop in ARMED -> IDLE next cycle with done=1.
- When undefined: no port, no ARMED state, start goes directly to RUN.

Decomposition:
- Shared package timing_gen_pkg:
  - state encoding constants ST_IDLE/ST_ARMED/ST_RUN;
  - default widths (CNT_WIDTH, FRAME_WIDTH);
  - channel slice helper macro/function for flattened compare buses.
- One natural sub-module: trig_sync_edge (2-FF sync + rising-edge pulse). It is instantiated only under TIMING_CNT_EXT_TRIG_EN.

Test Plan:
1. period=5, frame_num=2, start at T -> cnt_out 0,1,2,3,4,0,1,2,3,4. frame_start at T+1 and T+6. Return to IDLE at T+11 with done=1, frame_cnt_out=2, compares forced 0.
2. frame_num=0, period=3, stop at cnt_out=1 of frame 4 -> frame completes (cnt reaches 2). IDLE/done on the next cycle, frame_cnt_out=4.
3. period=8, compares ch0 rise/fall 2/6. update_req with new values 1/3 at cnt=4 -> old values hold until the wrap. New values appear with frame_start and update_ack in the same cycle.
4. period_in=0 -> treated as 1: cnt_out stays 0 and frame_start is high every cycle. frame_num=3 gives done 3 cycles after busy rises.
5. Reset asserted mid-frame (cnt=3) -> next cycle all outputs 0, no done pulse. A subsequent start runs normally.
6. TIMING_CNT_EXT_TRIG_EN, start then ext_trig rising 10 cycles later -> busy from T+1. First frame_start 4 cycles after the ext_trig edge. stop while ARMED -> done, IDLE.
